hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hs_match.sv | 13 +
 rtl/hazard_scoreboard.sv | 73 +++++++
 tb/tb_hazard_scoreboard.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: pipe entry record, forwarding constants and clog2 helper shared by the scoreboard
package hazard_pkg;
   localparam int MAX_RW = 8;
   localparam int FWD_RF = 0;
   typedef struct packed {
      logic              valid;
      logic [MAX_RW-1:0] rd;
      logic              we;
      logic              load;
   } entry_t;
   function automatic int clog2(input int n);
      int r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/hs_match.sv
// hs_match: one stage's producer compare for one source operand
module hs_match
   import hazard_pkg::*;
(
   input  logic              valid,
   input  logic              we,
   input  logic              use_s,
   input  logic [MAX_RW-1:0] rd,
   input  logic [MAX_RW-1:0] src,
   output logic              hit
);
   assign hit = valid && we && use_s && src != '0 && rd == src;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use stall and forwarding select; HAZARD_STATS_EN adds stall_cnt/fwd_cnt
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter  int NREG       = 32,
   parameter  int RW         = clog2(NREG),
   parameter  int DEPTH      = 3,
   parameter  int LOAD_STAGE = 2,
   localparam int FW         = clog2(DEPTH + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          issue_valid,
   input  logic [RW-1:0] issue_rd,
   input  logic          issue_we,
   input  logic          issue_load,
   input  logic [RW-1:0] src_a,
   input  logic [RW-1:0] src_b,
   input  logic          use_a,
   input  logic          use_b,
   input  logic          flush,
   output logic          stall,
   output logic [FW-1:0] fwd_a,
`ifdef HAZARD_STATS_EN
   output logic [FW-1:0] fwd_b,
   output logic [31:0]   stall_cnt,
   output logic [31:0]   fwd_cnt
`else
   output logic [FW-1:0] fwd_b
`endif
);
   entry_t [DEPTH:1]  pipe;
   entry_t            new_e;
   logic [DEPTH:1]    hit_a, hit_b;
   logic [FW-1:0]     sel_a, sel_b;
   logic              haz_a, haz_b;
   logic [MAX_RW-1:0] sa, sb;
   assign sa = MAX_RW'(src_a);
   assign sb = MAX_RW'(src_b);
   for (genvar k = 1; k <= DEPTH; k++) begin : g_m
      hs_match u_a (.valid(pipe[k].valid), .we(pipe[k].we), .use_s(use_a), .rd(pipe[k].rd), .src(sa), .hit(hit_a[k]));
      hs_match u_b (.valid(pipe[k].valid), .we(pipe[k].we), .use_s(use_b), .rd(pipe[k].rd), .src(sb), .hit(hit_b[k]));
   end
   // scan oldest to youngest so the youngest producer overwrites
   always_comb begin
      sel_a = FW'(FWD_RF);
      sel_b = FW'(FWD_RF);
      haz_a = 1'b0;
      haz_b = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
         sel_a = hit_a[k] ? FW'(k) : sel_a;
         sel_b = hit_b[k] ? FW'(k) : sel_b;
         haz_a = hit_a[k] ? pipe[k].load && k < LOAD_STAGE : haz_a;
         haz_b = hit_b[k] ? pipe[k].load && k < LOAD_STAGE : haz_b;
      end
   end
   assign stall = RST && issue_valid && !flush && (haz_a || haz_b);
   assign fwd_a = RST ? sel_a : FW'(FWD_RF);
   assign fwd_b = RST ? sel_b : FW'(FWD_RF);
   assign new_e = '{valid: issue_valid && !stall && !flush, rd: MAX_RW'(issue_rd), we: issue_we, load: issue_load};
   always_ff @(posedge CLK)
      pipe <= !RST ? '0 : {pipe[DEPTH-1:1], new_e};
`ifdef HAZARD_STATS_EN
   always_ff @(posedge CLK)
      if (!RST) begin
         stall_cnt <= '0;
         fwd_cnt   <= '0;
      end else begin
         stall_cnt <= stall_cnt + 32'(stall && !(&stall_cnt));
         fwd_cnt   <= fwd_cnt + 32'((fwd_a != '0 || fwd_b != '0) && !(&fwd_cnt));
      end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scoreboard bench, DEPTH=3/LOAD_STAGE=2 and DEPTH=5/LOAD_STAGE=3 instances
module tb_hazard_scoreboard;
   logic       CLK = 1'b0, RST = 1'b0;
   logic       issue_valid, issue_we, issue_load, use_a, use_b, flush;
   logic [4:0] issue_rd, src_a, src_b;
   logic       stall_a, stall_b;
   logic [1:0] fa_a, fb_a;
   logic [2:0] fa_b, fb_b;
`ifdef HAZARD_STATS_EN
   logic [31:0] sc_a, fc_a, sc_b, fc_b;
`endif
   int cyc = 0, checks = 0, errors = 0;
   typedef struct {
      int         cyc;
      bit         sel;
      logic       st;
      logic [3:0] fa;
      logic [3:0] fb;
      string      nm;
   } exp_t;
   exp_t q[$];

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   hazard_scoreboard u_a (
      .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
      .issue_load(issue_load), .src_a(src_a), .src_b(src_b), .use_a(use_a), .use_b(use_b),
      .flush(flush), .stall(stall_a), .fwd_a(fa_a), .fwd_b(fb_a)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(sc_a), .fwd_cnt(fc_a)
`endif
   );

   hazard_scoreboard #(.DEPTH(5), .LOAD_STAGE(3)) u_b (
      .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
      .issue_load(issue_load), .src_a(src_a), .src_b(src_b), .use_a(use_a), .use_b(use_b),
      .flush(flush), .stall(stall_b), .fwd_a(fa_b), .fwd_b(fb_b)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(sc_b), .fwd_cnt(fc_b)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   always @(negedge CLK) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin : pop
         exp_t e;
         e = q.pop_front();
         if (e.cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", e.nm, e.cyc, cyc);
         end else begin
            chk({e.nm, e.sel ? "_b_stall" : "_a_stall"}, 32'(e.sel ? stall_b : stall_a), 32'(e.st));
            chk({e.nm, e.sel ? "_b_fwd_a" : "_a_fwd_a"}, 32'(e.sel ? 4'(fa_b) : 4'(fa_a)), 32'(e.fa));
            chk({e.nm, e.sel ? "_b_fwd_b" : "_a_fwd_b"}, 32'(e.sel ? 4'(fb_b) : 4'(fb_a)), 32'(e.fb));
         end
      end
   end

   task automatic step(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                       input logic [4:0] sa, input logic ua, input logic [4:0] sb, input logic ub,
                       input logic fl);
      @(posedge CLK);
      #1;
      issue_valid = v; issue_rd = rd; issue_we = we; issue_load = ld;
      src_a = sa; use_a = ua; src_b = sb; use_b = ub; flush = fl;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic exp2(input string nm, input logic sta, input logic [3:0] faa, input logic [3:0] fba,
                       input logic stb, input logic [3:0] fab, input logic [3:0] fbb);
      q.push_back('{cyc, 1'b0, sta, faa, fba, nm});
      q.push_back('{cyc, 1'b1, stb, fab, fbb, nm});
   endtask

   task automatic gap_test(input int g, input logic [3:0] ea, input logic [3:0] eb);
      step(1, 3, 1, 0, 0, 0, 0, 0, 0);
      idle(g);
      step(1, 4, 1, 0, 3, 1, 0, 0, 0);
      exp2($sformatf("gap%0d", g), 0, ea, 0, 0, eb, 0);
      idle(6);
   endtask

   task automatic ldpair();
      step(1, 5, 1, 1, 0, 0, 0, 0, 0);
      step(1, 6, 1, 0, 5, 1, 0, 0, 0);
      exp2("ld1", 1, 1, 0, 1, 1, 0);
      step(1, 6, 1, 0, 5, 1, 0, 0, 0);
      exp2("ld2", 0, 2, 0, 1, 2, 0);
      step(1, 6, 1, 0, 5, 1, 0, 0, 0);
      exp2("ld3", 0, 3, 0, 0, 3, 0);
      idle(6);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      issue_valid = 0; issue_rd = 0; issue_we = 0; issue_load = 0;
      src_a = 0; src_b = 0; use_a = 0; use_b = 0; flush = 0;
      step(1, 3, 1, 1, 3, 1, 3, 1, 0);
      exp2("rst0", 0, 0, 0, 0, 0, 0);
      step(1, 3, 1, 1, 3, 1, 3, 1, 0);
      exp2("rst1", 0, 0, 0, 0, 0, 0);
      step(1, 4, 1, 0, 3, 1, 3, 1, 0);
      RST = 1'b1;
      exp2("rst_rel", 0, 0, 0, 0, 0, 0);
      idle(6);
      gap_test(0, 1, 1);
      gap_test(1, 2, 2);
      gap_test(2, 3, 3);
      gap_test(3, 0, 4);
      gap_test(4, 0, 5);
      step(1, 7, 1, 0, 0, 0, 0, 0, 0);
      idle(1);
      step(1, 7, 1, 0, 0, 0, 0, 0, 0);
      step(1, 8, 1, 0, 7, 1, 7, 1, 0);
      exp2("young", 0, 1, 1, 0, 1, 1);
      idle(6);
      step(1, 0, 1, 1, 0, 0, 0, 0, 0);
      step(1, 4, 1, 0, 0, 1, 0, 1, 0);
      exp2("r0", 0, 0, 0, 0, 0, 0);
      idle(6);
      step(1, 3, 1, 0, 0, 0, 0, 0, 0);
      step(1, 4, 1, 0, 3, 0, 3, 1, 0);
      exp2("use0", 0, 0, 1, 0, 0, 1);
      idle(6);
      step(1, 5, 1, 1, 0, 0, 0, 0, 0);
      step(1, 5, 1, 0, 5, 1, 0, 0, 1);
      exp2("flush", 0, 1, 0, 0, 1, 0);
      step(1, 9, 1, 0, 5, 1, 0, 0, 0);
      exp2("flushbub", 0, 2, 0, 1, 2, 0);
      idle(6);
      step(1, 5, 1, 1, 0, 0, 0, 0, 0);
      step(1, 6, 1, 0, 5, 1, 0, 0, 0);
      exp2("rs_st", 1, 1, 0, 1, 1, 0);
      step(1, 6, 1, 0, 5, 1, 0, 0, 0);
      RST = 1'b0;
      exp2("rs_low", 0, 0, 0, 0, 0, 0);
      step(1, 6, 1, 0, 5, 1, 0, 0, 0);
      RST = 1'b1;
      exp2("rs_after", 0, 0, 0, 0, 0, 0);
      idle(6);
      gap_test(0, 1, 1);
      repeat (3) ldpair();
`ifdef HAZARD_STATS_EN
      @(negedge CLK);
      chk("stall_cnt_a", sc_a, 3);
      chk("stall_cnt_b", sc_b, 6);
      chk("fwd_cnt_a", fc_a, 10);
      chk("fwd_cnt_b", fc_b, 10);
`endif
      idle(2);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left unchecked", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
